// File: rtl/lfsr_tpg.sv
// LFSR test-pattern generator with functional bypass.
// In bypass the functional requests reach the circuit under test unchanged.
// In test mode a start pulse drives num_patterns pseudo-random request words
// from a Galois LFSR, then raises done for the BIST controller.
module lfsr_tpg #(
    parameter int              N_REQ = 4,
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] request,
    input  logic             test_mode,
    input  logic             start,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [N_REQ-1:0] lfsr_request,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lfsr_state
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;
    logic             w_launch;
    logic             w_advance;

    // A run may only be launched from IDLE or DONE; start inside RUN is dropped.
    assign w_launch  = start & test_mode & (r_state != S_RUN);
    // The LFSR and counter only move while a run is live; an abort cycle freezes them.
    assign w_advance = (r_state == S_RUN) & test_mode;

    // Galois step and seed load, both steered away from the all-zero lock-up state.
    always_comb begin
        w_shift = {1'b0, r_lfsr[WIDTH-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
        w_step  = (w_shift == '0) ? SEED : w_shift;
        w_load  = (seed_in == '0) ? SEED : seed_in;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; a zero-length run skips RUN entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_next = (num_patterns == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!test_mode)                 w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))    w_next = S_DONE;
            end
            S_DONE: begin
                if (!test_mode)    w_next = S_IDLE;
                else if (w_launch) w_next = (num_patterns == '0) ? S_DONE : S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pattern counter: loaded on launch, counts remaining patterns during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_cnt <= '0;
        else if (w_launch)  r_cnt <= num_patterns;
        else if (w_advance) r_cnt <= r_cnt - CNT_W'(1);
    end

    // LFSR register: seed load outside RUN takes priority, so seed+start launches from seed_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_lfsr <= SEED;
        else if (seed_load && r_state != S_RUN)    r_lfsr <= w_load;
        else if (w_advance)                        r_lfsr <= w_step;
    end

    // Output decode and request mux; bypass is purely combinational.
    always_comb begin
        busy         = (r_state == S_RUN);
        done         = (r_state == S_DONE);
        lfsr_state   = r_lfsr;
        lfsr_request = '0;
        if (!test_mode)              lfsr_request = request;
        else if (r_state == S_RUN)   lfsr_request = r_lfsr[N_REQ-1:0];
    end

endmodule
